// File: rtl/interpol_pkg.sv
// Definitions shared by the interpolator and its front-end arbiter.
package interpol_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_DELIVER   = 3'd4
    } arb_state_e;

    localparam int N_DEF       = 16;
    localparam int M_DEF       = 16;
    localparam int QN_DEF      = 15;
    localparam int QM_DEF      = 15;
    localparam int TIMEOUT_DEF = 63;

endpackage

// File: rtl/interpol_arbiter_if.sv
// Requester-side and interpolator-side handshake bundle for interpol_arbiter.
interface interpol_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1,
    parameter int N    = 16,
    parameter int M    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] x_in;
    logic [NREQ-1:0]   gnt;
    logic [M-1:0]      y_out;
    logic [IDW-1:0]    y_id;
    logic              y_valid;
    logic              busy;
    logic              err;
    logic              err_clr;
    logic              ip_start;
    logic [N-1:0]      ip_x;
    logic              ip_ready;
    logic [M-1:0]      ip_y;

    // arbiter side
    modport slave (
        input  req, x_in, err_clr, ip_ready, ip_y,
        output gnt, y_out, y_id, y_valid, busy, err, ip_start, ip_x
    );

    // requesters + interpolator side
    modport master (
        output req, x_in, err_clr, ip_ready, ip_y,
        input  gnt, y_out, y_id, y_valid, busy, err, ip_start, ip_x
    );
endinterface

// File: rtl/interpol_arbiter_rr_pick.sv
// Round-robin first-one finder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            vld_o,
    output logic [IDW-1:0]  idx_o
);
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld_o && req_i[(int'(ptr_i) + i) % NREQ]) begin
                vld_o = 1'b1;
                idx_o = IDW'((int'(ptr_i) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/interpol_arbiter.sv
// Shares one interpolator among NREQ sources: round-robin grant, start/ready
// handshake, tagged result, and a watchdog that aborts a stuck transaction.
module interpol_arbiter
    import interpol_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int N       = N_DEF,
    parameter int M       = M_DEF,
    parameter int TOBITS  = 6,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clock,
    input logic reset_n,
    interpol_arbiter_if.slave bus
);
    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [TOBITS-1:0] wd_q, wd_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [N-1:0]    ip_x_q, ip_x_d;
    logic            ip_start_q, ip_start_d;
    logic [M-1:0]    y_out_q, y_out_d;
    logic [IDW-1:0]  y_id_q, y_id_d;
    logic            y_valid_q, y_valid_d;
    logic            err_q, err_d;
    logic            busy_q;

    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  ptr_nxt;
    logic            wd_expired;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign ptr_nxt    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    assign wd_expired = (wd_q == TOBITS'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        wd_d       = wd_q;
        gnt_d      = '0;
        ip_x_d     = ip_x_q;
        ip_start_d = 1'b0;
        y_out_d    = y_out_q;
        y_id_d     = y_id_q;
        y_valid_d  = 1'b0;
        err_d      = err_q & ~bus.err_clr;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld && bus.ip_ready) begin
                    gnt_d[pick_idx] = 1'b1;
                    ip_x_d          = bus.x_in[int'(pick_idx)*N +: N];
                    id_d            = pick_idx;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ip_start_d = 1'b1;
                wd_d       = '0;
                state_d    = S_WAIT_LOW;
            end
            // A completing handshake beats the watchdog in the same cycle.
            S_WAIT_LOW, S_WAIT_HIGH: begin
                wd_d = wd_q + 1'b1;
                if (state_q == S_WAIT_LOW && !bus.ip_ready) begin
                    state_d = S_WAIT_HIGH;
                end else if (state_q == S_WAIT_HIGH && bus.ip_ready) begin
                    y_out_d   = bus.ip_y;
                    y_id_d    = id_q;
                    y_valid_d = 1'b1;
                    state_d   = S_DELIVER;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    ptr_d   = ptr_nxt;
                    state_d = S_IDLE;
                end
            end
            S_DELIVER: begin
                ptr_d   = ptr_nxt;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            wd_q       <= '0;
            gnt_q      <= '0;
            ip_x_q     <= '0;
            ip_start_q <= 1'b0;
            y_out_q    <= '0;
            y_id_q     <= '0;
            y_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            wd_q       <= wd_d;
            gnt_q      <= gnt_d;
            ip_x_q     <= ip_x_d;
            ip_start_q <= ip_start_d;
            y_out_q    <= y_out_d;
            y_id_q     <= y_id_d;
            y_valid_q  <= y_valid_d;
            err_q      <= err_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ip_x     = ip_x_q;
    assign bus.ip_start = ip_start_q;
    assign bus.y_out    = y_out_q;
    assign bus.y_id     = y_id_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_interpol_arbiter.sv
// Directed bench for interpol_arbiter with a small interpolator stand-in
// (Y = 3*X + 5, ready drops after a stale cycle, 3-cycle compute).
module tb_interpol_arbiter;
    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic stuck = 1'b0;
    logic hold_low = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   yv_cnt = 0;

    always #5 clock = ~clock;

    interpol_arbiter_if #(.NREQ(2), .IDW(1), .N(16), .M(16)) bus ();

    interpol_arbiter #(
        .NREQ(2), .IDW(1), .N(16), .M(16), .TOBITS(6), .TIMEOUT(63)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // interpolator stand-in
    logic [1:0]  m_ph;
    logic [3:0]  m_cnt;
    logic [15:0] m_x, m_y;

    function automatic logic [15:0] f(input logic [15:0] x);
        return 16'(x * 16'd3 + 16'd5);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ph <= 2'd0; m_cnt <= 4'd0; m_x <= 16'd0; m_y <= 16'd0;
        end else begin
            case (m_ph)
                2'd0: if (bus.ip_start) begin m_x <= bus.ip_x; m_ph <= 2'd1; end
                2'd1: begin m_ph <= 2'd2; m_cnt <= 4'(LAT); end
                default: begin
                    if (m_cnt == 4'd1) begin m_ph <= 2'd0; m_y <= f(m_x); end
                    else m_cnt <= m_cnt - 4'd1;
                end
            endcase
        end
    end

    assign bus.ip_ready = stuck ? 1'b1 : (hold_low ? 1'b0 : (m_ph != 2'd2));
    assign bus.ip_y     = m_y;

    always @(negedge clock) if (bus.y_valid) yv_cnt <= yv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input int budget, output logic [1:0] g);
        int n = 0;
        g = 2'b00;
        while (n < budget && g == 2'b00) begin tick(); n++; g = bus.gnt; end
    endtask

    task automatic wait_yv(input string tag, input int budget, output logic id,
                           output logic [15:0] y, output int n);
        logic seen = 1'b0;
        n = 0; id = 1'b0; y = 16'd0;
        while (n < budget && !seen) begin
            tick(); n++;
            if (bus.y_valid) begin seen = 1'b1; id = bus.y_id; y = bus.y_out; end
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [1:0]  g;
        logic        id;
        logic [15:0] y;
        int          n, cnt0;

        bus.req = 2'b00; bus.x_in = 32'd0; bus.err_clr = 1'b0;
        #2;
        chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_start", {31'd0, bus.ip_start}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_yv", {31'd0, bus.y_valid}, 32'd0);
        chk("rst_yout", {16'd0, bus.y_out}, 32'd0);
        tick(); reset_n = 1'b1; tick();

        // 1: single request, exact cycle timing
        bus.x_in = {16'h0000, 16'h0200}; bus.req = 2'b01;
        tick();
        chk("s1_gnt", {30'd0, bus.gnt}, 32'd1);
        chk("s1_start_early", {31'd0, bus.ip_start}, 32'd0);
        bus.req = 2'b00;
        tick();
        chk("s1_gnt_pulse", {30'd0, bus.gnt}, 32'd0);
        chk("s1_start", {31'd0, bus.ip_start}, 32'd1);
        chk("s1_ipx", {16'd0, bus.ip_x}, 32'h0200);
        wait_yv("s1", 50, id, y, n);
        chk("s1_lat", n + 1, 32'd7);
        chk("s1_id", {31'd0, id}, 32'd0);
        chk("s1_y", {16'd0, y}, 32'h0605);
        tick();
        chk("s1_yv_pulse", {31'd0, bus.y_valid}, 32'd0);
        chk("s1_busy", {31'd0, bus.busy}, 32'd0);

        // 2: simultaneous requests from reset
        do_reset();
        cnt0 = yv_cnt;
        bus.x_in = {16'hFF00, 16'h0100}; bus.req = 2'b11;
        wait_gnt(10, g);
        chk("s2_gnt0", {30'd0, g}, 32'd1);
        bus.req = 2'b10;
        wait_yv("s2a", 50, id, y, n);
        chk("s2_id0", {31'd0, id}, 32'd0);
        chk("s2_y0", {16'd0, y}, 32'h0305);
        wait_gnt(10, g);
        chk("s2_gnt1", {30'd0, g}, 32'd2);
        bus.req = 2'b00;
        wait_yv("s2b", 50, id, y, n);
        chk("s2_id1", {31'd0, id}, 32'd1);
        chk("s2_y1", {16'd0, y}, 32'hFD05);
        repeat (10) tick();
        chk("s2_nvalid", yv_cnt - cnt0, 32'd2);

        // 3: fairness under continuous requests
        bus.req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_yv("s3", 50, id, y, n);
            chk("s3_id", {31'd0, id}, i % 2);
        end
        bus.req = 2'b00;
        tick(); tick();

        // 6: grant blocked while interpolator not ready
        hold_low = 1'b1; bus.x_in = {16'hFF00, 16'h0200}; bus.req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_nogrant", {30'd0, bus.gnt}, 32'd0);
        end
        hold_low = 1'b0;
        tick();
        chk("s6_gnt", {30'd0, bus.gnt}, 32'd1);
        bus.req = 2'b00;
        wait_yv("s6", 50, id, y, n);
        chk("s6_y", {16'd0, y}, 32'h0605);
        tick();

        // 4: watchdog abort (requester 1), then pointer moves past it
        stuck = 1'b1; cnt0 = yv_cnt; bus.req = 2'b10;
        wait_gnt(10, g);
        chk("s4_gnt", {30'd0, g}, 32'd2);
        bus.req = 2'b00;
        n = 0;
        while (n < 100 && !bus.err) begin tick(); n++; end
        chk("s4_err_time", n, 32'd64);
        chk("s4_busy", {31'd0, bus.busy}, 32'd0);
        chk("s4_novalid", yv_cnt - cnt0, 32'd0);
        tick(); tick();
        chk("s4_sticky", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("s4_clr", {31'd0, bus.err}, 32'd0);
        stuck = 1'b0;
        tick();
        bus.req = 2'b11;
        wait_gnt(10, g);
        chk("s4_next", {30'd0, g}, 32'd1);
        bus.req = 2'b00;
        wait_yv("s4", 50, id, y, n);
        tick();

        // 5: asynchronous reset mid-transaction
        bus.req = 2'b01;
        wait_gnt(10, g);
        bus.req = 2'b00;
        repeat (4) tick();
        cnt0 = yv_cnt;
        reset_n = 1'b0;
        #2;
        chk("s5_busy", {31'd0, bus.busy}, 32'd0);
        chk("s5_ipx", {16'd0, bus.ip_x}, 32'd0);
        chk("s5_yout", {16'd0, bus.y_out}, 32'd0);
        chk("s5_err_gnt", {29'd0, bus.err, bus.gnt}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("s5_novalid", yv_cnt - cnt0, 32'd0);
        bus.req = 2'b10;
        wait_gnt(10, g);
        chk("s5_gnt", {30'd0, g}, 32'd2);
        bus.req = 2'b00;
        wait_yv("s5", 50, id, y, n);
        chk("s5_id", {31'd0, id}, 32'd1);
        chk("s5_y", {16'd0, y}, 32'hFD05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end
endmodule
